// File: rtl/traffic_phase_sequencer.sv
// N-approach traffic-light sequencer: rotates right-of-way through green, yellow and
// all-red clearance intervals, using one shared down-counter and per-approach walk latches.
module traffic_phase_sequencer #(
    parameter int NUM_APPROACHES = 2,
    parameter int GREEN_TIME     = 55,
    parameter int YELLOW_TIME    = 5,
    parameter int ALLRED_TIME    = 30,
    parameter int PED_EXTEND     = 10,
    localparam int GMAX = GREEN_TIME + PED_EXTEND,
    localparam int DMAX = (GMAX > YELLOW_TIME)
                        ? ((GMAX > ALLRED_TIME) ? GMAX : ALLRED_TIME)
                        : ((YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME),
    localparam int TW   = $clog2(DMAX + 1),
    localparam int IW   = (NUM_APPROACHES > 2) ? $clog2(NUM_APPROACHES) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      hold_i,
    input  logic [NUM_APPROACHES-1:0] ped_req_i,
    output logic [NUM_APPROACHES-1:0] green_o,
    output logic [NUM_APPROACHES-1:0] yellow_o,
    output logic [NUM_APPROACHES-1:0] red_o,
    output logic [NUM_APPROACHES-1:0] walk_o,
    output logic [IW-1:0]             active_idx_o,
    output logic [1:0]                phase_o,
    output logic                      cycle_done_o
);

    // ALLRED: clearance, nobody moves | GREEN: active_idx moves | YELLOW: active_idx stopping
    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } phase_e;

    phase_e                    phase_q, phase_d;
    logic [IW-1:0]             idx_q, idx_d, idx_nx;
    logic [TW-1:0]             timer_q, timer_d;
    logic [NUM_APPROACHES-1:0] pend_q, pend_d;
    logic [NUM_APPROACHES-1:0] green_q, green_d, yellow_q, yellow_d;
    logic [NUM_APPROACHES-1:0] red_q, red_d, walk_q, walk_d;
    logic                      serve_q, serve_d;
    logic                      first_q, first_d;
    logic                      done_q, done_d;

    assign idx_nx = (idx_q == IW'(NUM_APPROACHES - 1)) ? '0 : idx_q + IW'(1);

    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        pend_d  = pend_q | ped_req_i;
        serve_d = serve_q;
        first_d = first_q;
        done_d  = 1'b0;

        if (!hold_i) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
            end else begin
                case (phase_q)
                    ALLRED: begin
                        phase_d         = GREEN;
                        idx_d           = idx_nx;
                        serve_d         = pend_q[idx_nx] | ped_req_i[idx_nx];
                        pend_d[idx_nx]  = 1'b0;
                        timer_d         = serve_d ? TW'(GREEN_TIME + PED_EXTEND - 1)
                                                  : TW'(GREEN_TIME - 1);
                        first_d         = 1'b0;
                    end
                    GREEN: begin
                        phase_d = YELLOW;
                        timer_d = TW'(YELLOW_TIME - 1);
                        serve_d = 1'b0;
                    end
                    default: begin
                        phase_d = ALLRED;
                        timer_d = TW'(ALLRED_TIME - 1);
                    end
                endcase
            end
            // The post-reset clearance also sits on the last approach, hence first_d.
            done_d = (phase_d == ALLRED) && (timer_d == '0)
                  && (idx_d == IW'(NUM_APPROACHES - 1)) && !first_d;
        end

        for (int i = 0; i < NUM_APPROACHES; i++) begin
            green_d[i]  = (phase_d == GREEN)  && (idx_d == IW'(i));
            yellow_d[i] = (phase_d == YELLOW) && (idx_d == IW'(i));
            walk_d[i]   = (phase_d == GREEN)  && (idx_d == IW'(i)) && serve_d;
        end
        red_d = ~(green_d | yellow_d);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            phase_q  <= ALLRED;
            idx_q    <= IW'(NUM_APPROACHES - 1);
            timer_q  <= TW'(ALLRED_TIME - 1);
            pend_q   <= '0;
            serve_q  <= 1'b0;
            first_q  <= 1'b1;
            done_q   <= 1'b0;
            green_q  <= '0;
            yellow_q <= '0;
            red_q    <= '1;
            walk_q   <= '0;
        end else begin
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            serve_q  <= serve_d;
            first_q  <= first_d;
            done_q   <= done_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
            walk_q   <= walk_d;
        end
    end

    assign green_o      = green_q;
    assign yellow_o     = yellow_q;
    assign red_o        = red_q;
    assign walk_o       = walk_q;
    assign active_idx_o = idx_q;
    assign phase_o      = phase_q;
    assign cycle_done_o = done_q;

endmodule
